uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, clk cycles per bit time (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter ODD_PARITY, default 0, parity sense: 0 = even, 1 = odd.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port resetN, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port data_in, input, 8 bits, byte to send; sampled only on acceptance.
REQ-006 The block SHALL have port start, input, 1 bit, request to send data_in.
REQ-007 The block SHALL have port tx, output, 1 bit, serial line; idle high.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-009 The block SHALL have port parity_out, output, 1 bit, parity bit of the byte currently or last sent.

Function
REQ-010 Acceptance SHALL occur on a rising clk edge where start=1 and busy=0; data_in is then latched into an internal shift register.
REQ-011 start while busy=1 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP with transitions IDLE->START (acceptance), START->DATA, DATA->PARITY after bit 7, PARITY->STOP, STOP->IDLE.
REQ-013 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLK_DIV cycles, counted by a bit-time counter cleared on acceptance and on every bit boundary.
REQ-014 tx SHALL be 0 in START, data bits LSB first in DATA, parity_out in PARITY, and 1 in STOP and IDLE.
REQ-015 tx SHALL fall on the clk edge immediately after the acceptance edge, giving a latency of 1 cycle.
REQ-016 busy SHALL be high from the acceptance edge until the final edge of the STOP bit time.
REQ-017 A start held high at the cycle busy falls SHALL be accepted then, so back-to-back frames have zero idle bit times.
REQ-018 parity_out SHALL be XOR of the latched byte XOR ODD_PARITY, computed at acceptance and held until the next acceptance.
REQ-019 A bit index counter (3 bits) SHALL count 0..7 without wrap-past; exit from DATA is on index 7 plus terminal bit-time count.
REQ-020 A frame with PARITY_EN SHALL total 11*CLK_DIV cycles of busy=1.

Reset
REQ-021 resetN=0 SHALL asynchronously force state=IDLE, tx=1, busy=0, parity_out=0, counters=0 and the shift register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately with tx=1, and no partial frame SHALL resume after release.
REQ-023 The first acceptance SHALL be possible on the first clk edge after resetN deasserts.

Configuration
REQ-024 Macro UART_TX_PARITY_EN, when defined, SHALL include the PARITY state and bit, giving an 11-bit frame.
REQ-025 When UART_TX_PARITY_EN is undefined, DATA SHALL go directly to STOP (10-bit frame, 10*CLK_DIV busy cycles) and parity_out SHALL be tied to 0.

Structure
REQ-026 The shared package uart_pkg SHALL hold the FSM state enumeration typedef, the DATA_BITS=8 constant and the default CLK_DIV constant, shared with the receiver.
REQ-027 One sub-module, uart_tx_bit_timer, SHALL be used: a CLK_DIV counter with clear input and one-cycle terminal pulse output.
REQ-028 The total RTL SHALL be 120-400 lines.

Verification (CLK_DIV=4, UART_TX_PARITY_EN defined unless noted)
REQ-029 Scenario: send 0xA5, even parity -> tx = 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop), each 4 cycles; busy high 44 cycles; parity_out=0.
REQ-030 Scenario: send 0x01 with ODD_PARITY=1 -> parity bit 0; send 0x03 -> parity bit 1; tx low exactly 1 cycle after the start edge.
REQ-031 Scenario: start held high across two frames (0x55 then 0xAA) -> the second start bit begins the cycle after the first stop bit ends; 88 contiguous busy cycles.
REQ-032 Scenario: pulse start with 0xFF at cycle 10 of a 0x00 frame -> ignored; the frame is unchanged and the line stays idle afterwards.
REQ-033 Scenario: resetN low during data bit 3 -> tx=1 and busy=0 in the same cycle without a clock edge; after release tx stays idle until a new start.
REQ-034 Scenario: UART_TX_PARITY_EN undefined, send 0x80 -> tx = 0,0,0,0,0,0,0,0,1,1; busy 40 cycles; parity_out constantly 0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver: the frame FSM
// state encoding, the data width and the default bit-time divider.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Payload bits per frame.
   localparam int DATA_BITS       = 8;
   localparam int BIT_IDX_W       = $clog2(DATA_BITS);

   // 50 MHz clock / 115200 baud, rounded.
   localparam int DEFAULT_CLK_DIV = 434;

   // Frame sequencer states. PARITY is always part of the encoding so that
   // both parity builds share one state type; it is simply never entered
   // when parity is compiled out.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Counts CLK_DIV clock cycles per bit time and flags the last cycle of each
// bit with a one-cycle terminal pulse. The count wraps on that pulse, so
// consecutive bit times follow each other with no gap.
//
// Ports
//   clk      in   clock, rising edge
//   resetN   in   asynchronous active-low reset
//   en_i     in   count while high; hold (and suppress tick_o) while low
//   clear_i  in   restart the bit time at zero on the next edge
//   tick_o   out  high during the final cycle of a bit time
// -----------------------------------------------------------------------------
module uart_tx_bit_timer #(
   parameter int CLK_DIV = 434
) (
   input  logic clk,
   input  logic resetN,
   input  logic en_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int              CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == LAST);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments
         // so every register samples the pre-edge values of the others.
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_tx_bit_timer

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// 8-bit UART transmitter: start bit, eight data bits LSB first, optional
// parity bit, one stop bit. Each bit lasts CLK_DIV clock cycles.
//
// Build option: define UART_TX_PARITY_EN to insert the parity bit
// (11-bit frame). Without it the frame is 10 bits and parity_out is 0.
//
// Parameters
//   CLK_DIV     clock cycles per bit time, 2..65535
//   ODD_PARITY  0 = even parity, 1 = odd parity
//
// Ports
//   clk         in   clock, rising edge
//   resetN      in   asynchronous active-low reset, aborts any frame
//   data_in     in   byte to send, sampled only when a frame is accepted
//   start       in   send request, accepted when the transmitter is free
//   tx          out  serial line, idle high, registered
//   busy        out  high from the acceptance edge to the end of the stop bit
//   parity_out  out  parity bit of the byte currently or last sent
// -----------------------------------------------------------------------------
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int ODD_PARITY = 0
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 start,
   output logic                 tx,
   output logic                 busy,
   output logic                 parity_out
);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

   uart_state_e            state_q, state_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic                   tx_q, tx_d;
   logic                   bit_tick;
   logic                   accept;

   assign busy = (state_q != ST_IDLE);
   assign tx   = tx_q;

   // A request is taken when idle, and also on the last cycle of the stop
   // bit so that a held start produces back-to-back frames with no gap.
   assign accept = start && ((state_q == ST_IDLE) ||
                             ((state_q == ST_STOP) && bit_tick));

   uart_tx_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk     (clk),
      .resetN  (resetN),
      .en_i    (busy),
      .clear_i (accept),
      .tick_o  (bit_tick)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_START;
         end
         ST_START: begin
            if (bit_tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick && (bit_idx_q == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
         ST_PARITY: begin
            if (bit_tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (bit_tick) state_d = accept ? ST_START : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs. tx is registered from the current state, so the line
   // follows the state by one cycle and is free of decode glitches.
   // ---------------------------------------------------------------------
   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[0];
         ST_PARITY: tx_d = parity_out;
         default:   tx_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: shift register and bit index
   // ---------------------------------------------------------------------
   always_comb begin
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      if (accept) begin
         shift_d   = data_in;
         bit_idx_d = '0;
      end else if ((state_q == ST_DATA) && bit_tick) begin
         shift_d = shift_q >> 1;
         // Saturates on the last bit; the next acceptance restarts it.
         if (bit_idx_q != LAST_BIT) begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         // NOTE: the shift register is a plain register, not a memory
         // array, so it can and does take the asynchronous reset.
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
      end
   end

   // ---------------------------------------------------------------------
   // Parity: computed once from the accepted byte and held until the next
   // acceptance.
   // ---------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
   localparam logic ODD_BIT = (ODD_PARITY != 0);

   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (accept) begin
         parity_d = (^data_in) ^ ODD_BIT;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_out = parity_q;
`else
   assign parity_out = 1'b0;
`endif

endmodule : uart_transmitter
